// File: rtl/nes_input_port.sv
// Controller-port serializer for the NES $4016/$4017 joypad interface.
// It snapshots up to four pads and the Power Pad while strobe is high, then shifts one bit per read pulse.
module nes_input_port #(
  parameter logic       FILL_BIT  = 1'b1,
  parameter logic [7:0] SIG_PORT0 = 8'h10,
  parameter logic [7:0] SIG_PORT1 = 8'h20
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  joy0_i,
  input  logic [7:0]  joy1_i,
  input  logic [7:0]  joy2_i,
  input  logic [7:0]  joy3_i,
  input  logic [11:0] powerpad_i,
  input  logic        fourscore_en_i,
  input  logic        powerpad_en_i,
  input  logic        strobe_i,
  input  logic [1:0]  joy_clk_i,
  output logic [3:0]  joy_data_o
);

  logic [7:0]  joy0_q, joy1_q, joy2_q, joy3_q;
  logic [11:0] pp_q;
  logic [4:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]  jclk_s_q, jclk_p_q;
  logic [1:0]  fall;
  logic [4:0]  limit;

  assign limit = fourscore_en_i ? 5'd24 : 5'd8;
  assign fall  = jclk_p_q & ~jclk_s_q;

  // Strobe has priority over a read edge in the same cycle; counters saturate at the frame length.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (strobe_i) begin
      cnt0_d = 5'd0;
      cnt1_d = 5'd0;
    end else begin
      if (fall[0] && (cnt0_q < limit)) cnt0_d = cnt0_q + 5'd1;
      if (fall[1] && (cnt1_q < limit)) cnt1_d = cnt1_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      joy0_q   <= 8'h00;
      joy1_q   <= 8'h00;
      joy2_q   <= 8'h00;
      joy3_q   <= 8'h00;
      pp_q     <= 12'h000;
      cnt0_q   <= 5'd0;
      cnt1_q   <= 5'd0;
      jclk_s_q <= 2'b00;
      jclk_p_q <= 2'b00;
    end else begin
      jclk_s_q <= joy_clk_i;
      jclk_p_q <= jclk_s_q;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      if (strobe_i) begin
        joy0_q <= joy0_i;
        joy1_q <= joy1_i;
        joy2_q <= joy2_i;
        joy3_q <= joy3_i;
        pp_q   <= powerpad_i;
      end
    end
  end

  // Indices 8..23 only exist in Four Score mode; n[2:0] is the bit within each 8-bit segment.
  function automatic logic pad_bit(input logic [4:0] n, input logic [7:0] lo,
                                   input logic [7:0] hi, input logic [7:0] sig,
                                   input logic fs);
    logic b;
    if (n < 5'd8)              b = lo[n[2:0]];
    else if (fs && n < 5'd16)  b = hi[n[2:0]];
    else if (fs && n < 5'd24)  b = sig[n[2:0]];
    else                       b = FILL_BIT;
    return b;
  endfunction

  logic d3, d4;

  always_comb begin
    d3 = FILL_BIT;
    d4 = FILL_BIT;
    case (cnt1_q)
      5'd0: begin d3 = pp_q[1];  d4 = pp_q[3];  end
      5'd1: begin d3 = pp_q[0];  d4 = pp_q[2];  end
      5'd2: begin d3 = pp_q[4];  d4 = pp_q[11]; end
      5'd3: begin d3 = pp_q[8];  d4 = pp_q[7];  end
      5'd4: d3 = pp_q[5];
      5'd5: d3 = pp_q[9];
      5'd6: d3 = pp_q[10];
      5'd7: d3 = pp_q[6];
      default: ;
    endcase
    if (!powerpad_en_i) begin
      d3 = 1'b0;
      d4 = 1'b0;
    end
  end

  assign joy_data_o = {d4, d3,
                       pad_bit(cnt1_q, joy1_q, joy3_q, SIG_PORT1, fourscore_en_i),
                       pad_bit(cnt0_q, joy0_q, joy2_q, SIG_PORT0, fourscore_en_i)};

endmodule

// File: tb/tb_nes_input_port.sv
// Randomized scoreboard bench for nes_input_port against a frame-table reference model.
module tb_nes_input_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  joy [4];
  logic [11:0] pp;
  logic        fs, ppen, strobe;
  logic [1:0]  jclk;
  logic [3:0]  joy_data;

  nes_input_port dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .joy0_i(joy[0]), .joy1_i(joy[1]), .joy2_i(joy[2]), .joy3_i(joy[3]),
    .powerpad_i(pp), .fourscore_en_i(fs), .powerpad_en_i(ppen),
    .strobe_i(strobe), .joy_clk_i(jclk), .joy_data_o(joy_data)
  );

  always #5 clk = ~clk;

  // reference model state: latched snapshot and bits already shifted per port
  logic [7:0]  mj [4];
  logic [11:0] mpp;
  int          n0, n1;

  logic [3:0] exp_q [$];
  string      nm_q  [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic port_bit(input int port, input int n);
    logic [23:0] frame;
    int lim;
    frame = (port == 0) ? {8'h10, mj[2], mj[0]} : {8'h20, mj[3], mj[1]};
    lim = fs ? 24 : 8;
    if (n >= lim) return 1'b1;
    return frame[n];
  endfunction

  function automatic logic [3:0] model_word();
    int map3 [8] = '{1, 0, 4, 8, 5, 9, 10, 6};
    int map4 [4] = '{3, 2, 11, 7};
    logic d3, d4;
    d3 = (n1 < 8) ? mpp[map3[n1]] : 1'b1;
    d4 = (n1 < 4) ? mpp[map4[n1]] : 1'b1;
    if (!ppen) begin d3 = 1'b0; d4 = 1'b0; end
    return {d4, d3, port_bit(1, n1), port_bit(0, n0)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_now(input string name);
    exp_q.push_back(model_word());
    nm_q.push_back(name);
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [3:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_checks++;
      if (joy_data !== e) begin
        n_fail++;
        $display("FAIL %s: joy_data=%b expected %b", nm, joy_data, e);
      end
    end
  end

  task automatic model_latch();
    for (int i = 0; i < 4; i++) mj[i] = joy[i];
    mpp = pp;
    n0 = 0;
    n1 = 0;
  endtask

  task automatic do_strobe();
    strobe = 1'b1;
    tick();
    model_latch();
    expect_now("strobe_live");
    strobe = 1'b0;
    tick();
  endtask

  // read pulse on the selected ports; the new bit must appear 2 clk after the fall, not 1
  task automatic pulse(input logic [1:0] mask, input string name);
    int lim;
    jclk = mask;
    tick();
    tick();
    jclk = 2'b00;
    tick();
    expect_now({name, "_hold"});
    lim = fs ? 24 : 8;
    if (mask[0] && n0 < lim) n0++;
    if (mask[1] && n1 < lim) n1++;
    expect_now(name);
  endtask

  initial begin
    int t;
    #2000000;
    $display("FAIL watchdog: time limit reached, pending=%0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin joy[i] = 8'h00; mj[i] = 8'h00; end
    pp = 12'h000; mpp = 12'h000; fs = 1'b0; ppen = 1'b0; strobe = 1'b0; jclk = 2'b00;
    n0 = 0; n1 = 0;
    tick(); tick();
    expect_now("reset_state");
    reset_n = 1'b1;
    tick();

    // standard 8-bit frame, fill and saturation
    joy[0] = 8'h81;
    do_strobe();
    for (int i = 0; i < 9; i++) pulse(2'b01, "p0_frame");
    for (int i = 0; i < 30; i++) pulse(2'b01, "p0_saturate");

    // Four Score frame on port 1
    fs = 1'b1; joy[1] = 8'h02; joy[3] = 8'h01;
    do_strobe();
    for (int i = 0; i < 25; i++) pulse(2'b10, "p1_fourscore");

    // Power Pad sequences
    fs = 1'b0; ppen = 1'b1; pp = 12'h001;
    do_strobe();
    for (int i = 0; i < 9; i++) pulse(2'b10, "pp_d3");
    pp = 12'h800;
    do_strobe();
    for (int i = 0; i < 5; i++) pulse(2'b10, "pp_d4");
    ppen = 1'b0;
    expect_now("pp_disabled");

    // strobe coinciding with the edge-detect cycle keeps the counter at 0
    joy[0] = 8'hA5;
    do_strobe();
    for (int i = 0; i < 3; i++) pulse(2'b01, "pre_strobe_edge");
    jclk = 2'b01; tick(); tick();
    jclk = 2'b00; tick();
    strobe = 1'b1; tick();
    strobe = 1'b0;
    model_latch();
    expect_now("strobe_vs_edge");
    pulse(2'b11, "both_ports");
    pulse(2'b11, "both_ports");

    // async reset mid-frame
    joy[0] = 8'hFF; joy[1] = 8'hFF; pp = 12'hFFF; ppen = 1'b1;
    do_strobe();
    for (int i = 0; i < 5; i++) pulse(2'b01, "pre_reset");
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) mj[i] = 8'h00;
    mpp = 12'h000; n0 = 0; n1 = 0;
    expect_now("reset_async");
    reset_n = 1'b1;
    tick();
    expect_now("post_reset_zeros");
    pulse(2'b11, "post_reset_read");

    // fourscore switched off mid-frame, then back on
    fs = 1'b1; joy[2] = 8'h5A;
    do_strobe();
    for (int i = 0; i < 12; i++) pulse(2'b01, "fs_pre_switch");
    fs = 1'b0;
    expect_now("fs_off_fill");
    pulse(2'b01, "fs_off_pulse");
    fs = 1'b1;
    expect_now("fs_back_on");

    // inputs change mid-frame without a strobe
    fs = 1'b0; joy[0] = 8'h3C;
    do_strobe();
    for (int i = 0; i < 8; i++) begin
      joy[0] = 8'($urandom); pp = 12'($urandom);
      pulse(2'b01, "snapshot_hold");
    end

    // randomized frames
    for (int it = 0; it < 12; it++) begin
      int k;
      for (int i = 0; i < 4; i++) joy[i] = 8'($urandom);
      pp = 12'($urandom); fs = 1'($urandom); ppen = 1'($urandom);
      do_strobe();
      k = $urandom_range(0, 28);
      for (int p = 0; p < k; p++) begin
        if ($urandom_range(0, 5) == 0) fs = ~fs;
        if ($urandom_range(0, 3) == 0) joy[$urandom_range(0, 3)] = 8'($urandom);
        pulse(2'($urandom_range(1, 3)), "random");
      end
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
